// File: rtl/fll_lock.sv
// ----------------------------------------------------------------------------
// fll_lock
//   Frequency lock detector for the FLL, clocked in the reference domain.
//   Over a programmable window it counts reference increment pulses (inc_i)
//   and feedback increment pulses (inc_o). Each closed window yields a signed
//   error (ref - feedback). A hysteresis FSM turns runs of good or bad windows
//   into the lock indication.
//
// Ports
//   clk_i   in   1      reference clock (only clock)
//   rst_ni  in   1      asynchronous active-low reset
//   ena_i   in   1      detector enable; low forces OFF and drops any partial window
//   win_i   in   WW     window length minus one (sampled when a window is loaded)
//   inc_i   in   1      reference increment pulse
//   inc_o   in   1      feedback increment pulse (already in clk_i domain)
//   vld_o   out  1      one-cycle pulse: window closed, err_o updated
//   err_o   out  CW+1   signed ref-minus-feedback count of the last window
//   lck_o   out  1      lock indication (state LOCK or HOLD)
//   sta_o   out  2      FSM state: 0 OFF, 1 ACQ, 2 LOCK, 3 HOLD
// ----------------------------------------------------------------------------
module fll_lock #(
    parameter int CW  = 8,
    parameter int WW  = 12,
    parameter int TOL = 2,
    parameter int LCK = 4,
    parameter int ULK = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ena_i,
    input  logic [WW-1:0] win_i,
    input  logic          inc_i,
    input  logic          inc_o,
    output logic          vld_o,
    output logic [CW:0]   err_o,
    output logic          lck_o,
    output logic [1:0]    sta_o
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int GW = $clog2(LCK + 1);
    localparam int BW = $clog2(ULK + 1);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW:0]   TOL_V   = (CW+1)'(TOL);
    localparam logic [GW-1:0] LCK_V   = GW'(LCK);
    localparam logic [BW-1:0] ULK_V   = BW'(ULK);

    state_t        state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] cnt_r_q, cnt_r_d;
    logic [CW-1:0] cnt_f_q, cnt_f_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          vld_q, vld_d;
    logic [CW:0]   err_q, err_d;
    logic          lck_q, lck_d;

    // Counts including this cycle's pulse, saturating at the top.
    logic [CW-1:0] cnt_r_inc, cnt_f_inc;
    logic [CW:0]   err_win, err_abs;
    logic          win_sat, win_good;
    logic [GW-1:0] gcnt_inc;
    logic [BW-1:0] bcnt_inc;

    always_comb begin
        cnt_r_inc = (cnt_r_q == CNT_MAX) ? CNT_MAX : cnt_r_q + {{(CW-1){1'b0}}, inc_i};
        cnt_f_inc = (cnt_f_q == CNT_MAX) ? CNT_MAX : cnt_f_q + {{(CW-1){1'b0}}, inc_o};
        err_win   = {1'b0, cnt_r_inc} - {1'b0, cnt_f_inc};
        // Magnitude fits in CW+1 bits unsigned since |err| <= 2^CW-1.
        err_abs   = err_win[CW] ? (~err_win + (CW+1)'(1)) : err_win;
        // A counter stuck at its ceiling means the true count is unknown,
        // so such a window can never vouch for lock.
        win_sat   = (cnt_r_inc == CNT_MAX) || (cnt_f_inc == CNT_MAX);
        win_good  = (err_abs <= TOL_V) && !win_sat;
        gcnt_inc  = gcnt_q + GW'(1);
        bcnt_inc  = bcnt_q + BW'(1);
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        cnt_r_d = cnt_r_q;
        cnt_f_d = cnt_f_q;
        gcnt_d  = gcnt_q;
        bcnt_d  = bcnt_q;
        vld_d   = 1'b0;
        err_d   = err_q;

        if (!ena_i) begin
            // Abort: drop the partial window, keep the last reported error.
            state_d = ST_OFF;
            wcnt_d  = '0;
            cnt_r_d = '0;
            cnt_f_d = '0;
            gcnt_d  = '0;
            bcnt_d  = '0;
        end else if (state_q == ST_OFF) begin
            state_d = ST_ACQ;
            wcnt_d  = win_i;
            cnt_r_d = '0;
            cnt_f_d = '0;
            gcnt_d  = '0;
            bcnt_d  = '0;
        end else if (wcnt_q != '0) begin
            wcnt_d  = wcnt_q - WW'(1);
            cnt_r_d = cnt_r_inc;
            cnt_f_d = cnt_f_inc;
        end else begin
            // Window-end cycle: this cycle's pulses belong to the closing window.
            vld_d   = 1'b1;
            err_d   = err_win;
            cnt_r_d = '0;
            cnt_f_d = '0;
            wcnt_d  = win_i;
            case (state_q)
                ST_ACQ: begin
                    if (!win_good) begin
                        gcnt_d = '0;
                    end else if (gcnt_inc >= LCK_V) begin
                        state_d = ST_LOCK;
                        gcnt_d  = '0;
                    end else begin
                        gcnt_d = gcnt_inc;
                    end
                end
                ST_LOCK: begin
                    if (!win_good) begin
                        if (ULK == 1) begin
                            state_d = ST_ACQ;
                            gcnt_d  = '0;
                            bcnt_d  = '0;
                        end else begin
                            state_d = ST_HOLD;
                            bcnt_d  = BW'(1);
                        end
                    end
                end
                default: begin // ST_HOLD
                    if (win_good) begin
                        state_d = ST_LOCK;
                        bcnt_d  = '0;
                    end else if (bcnt_inc >= ULK_V) begin
                        state_d = ST_ACQ;
                        gcnt_d  = '0;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_inc;
                    end
                end
            endcase
        end

        lck_d = (state_d == ST_LOCK) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_OFF;
            wcnt_q  <= '0;
            cnt_r_q <= '0;
            cnt_f_q <= '0;
            gcnt_q  <= '0;
            bcnt_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= '0;
            lck_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            cnt_r_q <= cnt_r_d;
            cnt_f_q <= cnt_f_d;
            gcnt_q  <= gcnt_d;
            bcnt_q  <= bcnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            lck_q   <= lck_d;
        end
    end

    assign vld_o = vld_q;
    assign err_o = err_q;
    assign lck_o = lck_q;
    assign sta_o = state_q;

endmodule

// File: tb/tb_fll_lock.sv
// ----------------------------------------------------------------------------
// tb_fll_lock
//   Scoreboard bench for fll_lock. The stimulus process pushes the expected
//   window result (error, state, lock, closing cycle) as it drives each window;
//   a monitor pops and compares whenever vld_o is seen.
// ----------------------------------------------------------------------------
module tb_fll_lock;

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_ACQ  = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ena_i;
    logic [11:0] win_i;
    logic        inc_i;
    logic        inc_o;
    logic        vld_o;
    logic [8:0]  err_o;
    logic        lck_o;
    logic [1:0]  sta_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [8:0] err;
        logic [1:0] sta;
        logic       lck;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    fll_lock dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ena_i  (ena_i),
        .win_i  (win_i),
        .inc_i  (inc_i),
        .inc_o  (inc_o),
        .vld_o  (vld_o),
        .err_o  (err_o),
        .lck_o  (lck_o),
        .sta_o  (sta_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one full window of ncyc cycles. Pulses fire where i % period == 0
    // (period 0 = none); *_last adds a pulse on the window-end cycle.
    task automatic drive_window(input int ncyc, input int rp, input int fp,
                                input bit r_last, input bit f_last,
                                input logic [8:0] e_err, input logic [1:0] e_sta,
                                input logic e_lck);
        exp_t e;
        e.err = e_err;
        e.sta = e_sta;
        e.lck = e_lck;
        e.cyc = cyc + ncyc;
        exp_q.push_back(e);
        for (int i = 0; i < ncyc; i++) begin
            inc_i = ((rp > 0) && ((i % rp) == 0)) || (r_last && (i == ncyc - 1));
            inc_o = ((fp > 0) && ((i % fp) == 0)) || (f_last && (i == ncyc - 1));
            @(posedge clk_i);
            #1;
        end
        inc_i = 1'b0;
        inc_o = 1'b0;
    endtask

    // Monitor: every vld_o pulse must match the next expected window.
    always @(negedge clk_i) begin
        if (rst_ni && vld_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL stray_vld: vld_o high with no window expected (cycle %0d) err=%0h", cyc, err_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (err_o !== e.err || sta_o !== e.sta || lck_o !== e.lck || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL window: got err=%0h sta=%0d lck=%0b cyc=%0d expected err=%0h sta=%0d lck=%0b cyc=%0d",
                             err_o, sta_o, lck_o, cyc, e.err, e.sta, e.lck, e.cyc);
                end else begin
                    $display("window ok: err=%0h sta=%0d lck=%0b cyc=%0d", err_o, sta_o, lck_o, cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_ni = 1'b0;
        ena_i  = 1'b0;
        win_i  = 12'd0;
        inc_i  = 1'b0;
        inc_o  = 1'b0;
        #1;
        chk("rst_vld", vld_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_lck", lck_o, 0);
        chk("rst_sta", sta_o, S_OFF);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Acquire: 10 vs 10 pulses per 100-cycle window, lock on the 4th.
        win_i = 12'd99;
        ena_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("acq_entry_sta", sta_o, S_ACQ);
        for (int k = 0; k < 4; k++)
            drive_window(100, 10, 10, 0, 0, 9'd0, (k == 3) ? S_LOCK : S_ACQ, k == 3);

        // Loss: 10 vs 13 pulses -> err -3; HOLD then ACQ.
        drive_window(100, 10, 8, 0, 0, 9'h1FD, S_HOLD, 1'b1);
        drive_window(100, 10, 8, 0, 0, 9'h1FD, S_ACQ,  1'b0);

        // Boundary: pulses on the window-end cycle count in the closing window.
        drive_window(100, 0, 0, 1, 0, 9'd1, S_ACQ, 1'b0);
        drive_window(100, 0, 0, 1, 1, 9'd0, S_ACQ, 1'b0);
        // Window already loaded with 99; the 0 takes effect after this one.
        win_i = 12'd0;
        drive_window(100, 0, 0, 0, 0, 9'd0, S_ACQ, 1'b0);
        drive_window(1, 0, 0, 0, 0, 9'd0, S_LOCK, 1'b1);
        drive_window(1, 0, 0, 1, 0, 9'd1, S_LOCK, 1'b1);
        win_i = 12'd299;
        drive_window(1, 0, 0, 1, 1, 9'd0, S_LOCK, 1'b1);

        // Saturation: both counts stick at 255, err 0 but window is bad.
        drive_window(300, 1, 1, 0, 0, 9'd0, S_HOLD, 1'b1);
        drive_window(300, 1, 1, 0, 0, 9'd0, S_ACQ,  1'b0);
        win_i = 12'd9;
        drive_window(300, 1, 1, 0, 0, 9'd0, S_ACQ,  1'b0);

        // Relock with 10-cycle windows; last window reports err +1.
        for (int k = 0; k < 3; k++)
            drive_window(10, 0, 0, 0, 0, 9'd0, S_ACQ, 1'b0);
        drive_window(10, 0, 0, 1, 0, 9'd1, S_LOCK, 1'b1);

        // Abort mid-window in LOCK.
        inc_i = 1'b1;
        repeat (5) begin
            @(posedge clk_i);
            #1;
        end
        inc_i = 1'b0;
        ena_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("abort_sta", sta_o, S_OFF);
        chk("abort_lck", lck_o, 0);
        chk("abort_vld", vld_o, 0);
        chk("abort_err_hold", err_o, 9'd1);
        repeat (12) begin
            @(posedge clk_i);
            #1;
            chk("abort_no_vld", vld_o, 0);
        end

        // Re-enable: first window closes exactly win_i+1 cycles after ACQ entry.
        ena_i = 1'b1;
        @(posedge clk_i);
        #1;
        drive_window(10, 5, 0, 0, 0, 9'd2,   S_ACQ, 1'b0);
        drive_window(10, 0, 5, 0, 0, 9'h1FE, S_ACQ, 1'b0);
        drive_window(10, 0, 0, 0, 0, 9'd0,   S_ACQ, 1'b0);
        drive_window(10, 0, 0, 0, 0, 9'd0,   S_LOCK, 1'b1);

        // Reset mid-window while locked: outputs clear without a clock edge.
        inc_i = 1'b1;
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        chk("pre_rst_lck", lck_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_vld", vld_o, 0);
        chk("async_rst_err", err_o, 0);
        chk("async_rst_lck", lck_o, 0);
        chk("async_rst_sta", sta_o, S_OFF);
        inc_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("held_rst_sta", sta_o, S_OFF);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
